// File: rtl/rq_arb_pkg.sv
// Shared types for the two-source RQ arbiter: FSM state, beat payload and the
// tdata bit that selects a Type 1 configuration request.
package rq_arb_pkg;

    localparam int DFLT_IF_WIDTH    = 512;
    localparam int DFLT_TKEEP_WIDTH = 16;
    localparam int DFLT_TUSER_WIDTH = 183;

    // Clearing this bit on the first beat turns a Type 1 config request into Type 0.
    localparam int RQ_T1_BIT = 75;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DFLT_IF_WIDTH-1:0]    tdata;
        logic [DFLT_TKEEP_WIDTH-1:0] tkeep;
        logic                        tlast;
        logic [DFLT_TUSER_WIDTH-1:0] tuser;
    } rq_beat_t;

endpackage

// File: rtl/rq_arb_reg_slice.sv
// Single-entry output register for the merged RQ stream. in_valid must only be
// raised in a cycle where can_load is high.
module rq_arb_reg_slice
    import rq_arb_pkg::*;
#(
    parameter type beat_t = rq_beat_t
) (
    input  logic  user_clk,
    input  logic  user_reset,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  can_load,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values; the data path is reset too because
            // the core-facing outputs must read zero out of reset.
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (can_load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_beat <= in_beat;
            end
        end
    end

endmodule

// File: rtl/rq_two_source_arbiter.sv
// Packet-level round-robin merge of the local requester (s0) and the switch
// forwarding path (s1) onto the core RQ port, with optional Type 1 -> Type 0.
module rq_two_source_arbiter
    import rq_arb_pkg::*;
#(
    parameter int IF_WIDTH       = 512,
    parameter int TKEEP_WIDTH    = 16,
    parameter int RQ_TUSER_WIDTH = 183,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [1:0]                cfg_t1_to_t0,

    input  logic [IF_WIDTH-1:0]       s0_axis_rq_tdata,
    input  logic [TKEEP_WIDTH-1:0]    s0_axis_rq_tkeep,
    input  logic                      s0_axis_rq_tlast,
    input  logic [RQ_TUSER_WIDTH-1:0] s0_axis_rq_tuser,
    input  logic                      s0_axis_rq_tvalid,
    output logic                      s0_axis_rq_tready,

    input  logic [IF_WIDTH-1:0]       s1_axis_rq_tdata,
    input  logic [TKEEP_WIDTH-1:0]    s1_axis_rq_tkeep,
    input  logic                      s1_axis_rq_tlast,
    input  logic [RQ_TUSER_WIDTH-1:0] s1_axis_rq_tuser,
    input  logic                      s1_axis_rq_tvalid,
    output logic                      s1_axis_rq_tready,

    output logic [IF_WIDTH-1:0]       m_axis_rq_tdata,
    output logic [TKEEP_WIDTH-1:0]    m_axis_rq_tkeep,
    output logic                      m_axis_rq_tlast,
    output logic [RQ_TUSER_WIDTH-1:0] m_axis_rq_tuser,
    output logic                      m_axis_rq_tvalid,
    input  logic                      m_axis_rq_tready,

    output logic [CNT_WIDTH-1:0]      pkt_cnt0,
    output logic [CNT_WIDTH-1:0]      pkt_cnt1,
    output logic [1:0]                grant
);

    typedef struct packed {
        logic [IF_WIDTH-1:0]       tdata;
        logic [TKEEP_WIDTH-1:0]    tkeep;
        logic                      tlast;
        logic [RQ_TUSER_WIDTH-1:0] tuser;
    } beat_t;

    arb_state_t state;
    logic       rr_last;
    logic       can_load;
    logic       sel;
    logic       sel_valid;
    logic       accept;
    logic       first_beat;
    beat_t      sel_beat;
    beat_t      out_beat;

    // Every beat accepted while IDLE opens a packet; beats taken while owning never do.
    assign first_beat = (state == IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        sel       = 1'b0;
        sel_valid = 1'b0;
        case (state)
            OWN0: begin
                sel       = 1'b0;
                sel_valid = s0_axis_rq_tvalid;
            end
            OWN1: begin
                sel       = 1'b1;
                sel_valid = s1_axis_rq_tvalid;
            end
            default: begin
                sel       = (s0_axis_rq_tvalid && s1_axis_rq_tvalid) ? !rr_last : s1_axis_rq_tvalid;
                sel_valid = s0_axis_rq_tvalid || s1_axis_rq_tvalid;
            end
        endcase
    end

    assign accept = sel_valid && can_load && !user_reset;

    // An owner keeps its ready even while it idles mid-packet; in IDLE only a real winner gets it.
    assign s0_axis_rq_tready = !user_reset && can_load && !sel && (state != IDLE || sel_valid);
    assign s1_axis_rq_tready = !user_reset && can_load &&  sel && (state != IDLE || sel_valid);

    always_comb begin
        sel_beat.tdata = sel ? s1_axis_rq_tdata : s0_axis_rq_tdata;
        sel_beat.tkeep = sel ? s1_axis_rq_tkeep : s0_axis_rq_tkeep;
        sel_beat.tlast = sel ? s1_axis_rq_tlast : s0_axis_rq_tlast;
        sel_beat.tuser = sel ? s1_axis_rq_tuser : s0_axis_rq_tuser;
        if (first_beat && cfg_t1_to_t0[sel]) begin
            sel_beat.tdata[RQ_T1_BIT] = 1'b0;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (state)
            OWN0:    grant = 2'b01;
            OWN1:    grant = 2'b10;
            default: if (accept) grant = sel ? 2'b10 : 2'b01;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                rr_last <= sel;
                if (!sel_beat.tlast) begin
                    state <= sel ? OWN1 : OWN0;
                end
            end else if (sel_beat.tlast) begin
                state <= IDLE;
            end
            if (sel_beat.tlast) begin
                if (sel) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
                else     pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            end
        end
    end

    rq_arb_reg_slice #(
        .beat_t (beat_t)
    ) u_out_slice (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .in_beat    (sel_beat),
        .in_valid   (accept),
        .can_load   (can_load),
        .out_beat   (out_beat),
        .out_valid  (m_axis_rq_tvalid),
        .out_ready  (m_axis_rq_tready)
    );

    assign m_axis_rq_tdata = out_beat.tdata;
    assign m_axis_rq_tkeep = out_beat.tkeep;
    assign m_axis_rq_tlast = out_beat.tlast;
    assign m_axis_rq_tuser = out_beat.tuser;

endmodule

// File: tb/tb_rq_two_source_arbiter.sv
// Self-checking bench: queued packet sources, a packet-level arbitration and
// output model, and scenario tasks for conversion, fairness, stalls and reset.
module tb_rq_two_source_arbiter;

    localparam int W = 512;
    localparam int K = 16;
    localparam int U = 183;
    localparam int C = 16;

    typedef struct {
        logic [W-1:0] d;
        logic [K-1:0] k;
        logic         l;
        logic [U-1:0] u;
    } tb_beat_t;

    logic         user_clk = 1'b0;
    logic         user_reset = 1'b1;
    logic [1:0]   cfg_t1_to_t0 = 2'b00;
    logic [W-1:0] s0_axis_rq_tdata = '0;
    logic [K-1:0] s0_axis_rq_tkeep = '0;
    logic         s0_axis_rq_tlast = 1'b0;
    logic [U-1:0] s0_axis_rq_tuser = '0;
    logic         s0_axis_rq_tvalid = 1'b0;
    logic         s0_axis_rq_tready;
    logic [W-1:0] s1_axis_rq_tdata = '0;
    logic [K-1:0] s1_axis_rq_tkeep = '0;
    logic         s1_axis_rq_tlast = 1'b0;
    logic [U-1:0] s1_axis_rq_tuser = '0;
    logic         s1_axis_rq_tvalid = 1'b0;
    logic         s1_axis_rq_tready;
    logic [W-1:0] m_axis_rq_tdata;
    logic [K-1:0] m_axis_rq_tkeep;
    logic         m_axis_rq_tlast;
    logic [U-1:0] m_axis_rq_tuser;
    logic         m_axis_rq_tvalid;
    logic         m_axis_rq_tready = 1'b1;
    logic [C-1:0] pkt_cnt0;
    logic [C-1:0] pkt_cnt1;
    logic [1:0]   grant;

    always #5 user_clk = ~user_clk;

    rq_two_source_arbiter #(
        .IF_WIDTH       (W),
        .TKEEP_WIDTH    (K),
        .RQ_TUSER_WIDTH (U),
        .CNT_WIDTH      (C)
    ) dut (
        .user_clk          (user_clk),
        .user_reset        (user_reset),
        .cfg_t1_to_t0      (cfg_t1_to_t0),
        .s0_axis_rq_tdata  (s0_axis_rq_tdata),
        .s0_axis_rq_tkeep  (s0_axis_rq_tkeep),
        .s0_axis_rq_tlast  (s0_axis_rq_tlast),
        .s0_axis_rq_tuser  (s0_axis_rq_tuser),
        .s0_axis_rq_tvalid (s0_axis_rq_tvalid),
        .s0_axis_rq_tready (s0_axis_rq_tready),
        .s1_axis_rq_tdata  (s1_axis_rq_tdata),
        .s1_axis_rq_tkeep  (s1_axis_rq_tkeep),
        .s1_axis_rq_tlast  (s1_axis_rq_tlast),
        .s1_axis_rq_tuser  (s1_axis_rq_tuser),
        .s1_axis_rq_tvalid (s1_axis_rq_tvalid),
        .s1_axis_rq_tready (s1_axis_rq_tready),
        .m_axis_rq_tdata   (m_axis_rq_tdata),
        .m_axis_rq_tkeep   (m_axis_rq_tkeep),
        .m_axis_rq_tlast   (m_axis_rq_tlast),
        .m_axis_rq_tuser   (m_axis_rq_tuser),
        .m_axis_rq_tvalid  (m_axis_rq_tvalid),
        .m_axis_rq_tready  (m_axis_rq_tready),
        .pkt_cnt0          (pkt_cnt0),
        .pkt_cnt1          (pkt_cnt1),
        .grant             (grant)
    );

    int checks   = 0;
    int failures = 0;

    tb_beat_t q0[$];
    tb_beat_t q1[$];
    tb_beat_t out_log[$];

    // Reference model: owner is -1 between packets, last_w is the last packet winner.
    int       owner;
    int       last_w;
    bit       in_pkt[2];
    int       cnt[2];
    logic     exp_ov;
    tb_beat_t exp_out;

    int gap_pct  = 0;
    bit rand_rdy = 1'b0;
    bit log_en   = 1'b1;

    function automatic tb_beat_t make_beat(int src, int pkt, int idx, bit last, bit t1);
        tb_beat_t     b;
        logic [191:0] uw;
        for (int i = 0; i < W / 32; i++) b.d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 6; i++) uw[i*32 +: 32] = $urandom;
        b.d[7:0]   = 8'(src);
        b.d[15:8]  = 8'(pkt);
        b.d[23:16] = 8'(idx);
        b.d[75]    = t1;
        b.k        = K'($urandom);
        b.l        = last;
        b.u        = uw[U-1:0];
        return b;
    endfunction

    task automatic push_pkt(int src, int pkt, int len, bit t1_first, bit t1_rest);
        tb_beat_t b;
        for (int i = 0; i < len; i++) begin
            b = make_beat(src, pkt, i, (i == len - 1), (i == 0) ? t1_first : t1_rest);
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        last_w    = 1;
        in_pkt[0] = 1'b0;
        in_pkt[1] = 1'b0;
        cnt[0]    = 0;
        cnt[1]    = 0;
        exp_ov    = 1'b0;
        exp_out   = '{default: '0};
    endtask

    task automatic drive();
        if (rand_rdy) m_axis_rq_tready = ($urandom_range(3) != 0);
        s0_axis_rq_tvalid = (q0.size() > 0) && ($urandom_range(99) >= gap_pct);
        s1_axis_rq_tvalid = (q1.size() > 0) && ($urandom_range(99) >= gap_pct);
        if (q0.size() > 0) begin
            s0_axis_rq_tdata = q0[0].d; s0_axis_rq_tkeep = q0[0].k;
            s0_axis_rq_tlast = q0[0].l; s0_axis_rq_tuser = q0[0].u;
        end else begin
            s0_axis_rq_tdata = '0; s0_axis_rq_tkeep = '0; s0_axis_rq_tlast = 1'b0; s0_axis_rq_tuser = '0;
        end
        if (q1.size() > 0) begin
            s1_axis_rq_tdata = q1[0].d; s1_axis_rq_tkeep = q1[0].k;
            s1_axis_rq_tlast = q1[0].l; s1_axis_rq_tuser = q1[0].u;
        end else begin
            s1_axis_rq_tdata = '0; s1_axis_rq_tkeep = '0; s1_axis_rq_tlast = 1'b0; s1_axis_rq_tuser = '0;
        end
    endtask

    // One clock: drive after the edge, compare and advance the model at the falling edge.
    task automatic cycle();
        tb_beat_t   b;
        tb_beat_t   eb;
        tb_beat_t   ob;
        int         w;
        logic       can_load;
        logic       acc;
        logic       exp_r0;
        logic       exp_r1;
        logic [1:0] exp_g;
        drive();
        @(negedge user_clk);
        if (user_reset) begin
            checks++;
            if (s0_axis_rq_tready !== 1'b0 || s1_axis_rq_tready !== 1'b0) begin
                failures++;
                $display("FAIL tready_in_reset: got s0=%b s1=%b, expected 0 0", s0_axis_rq_tready, s1_axis_rq_tready);
            end
            model_reset();
            q0.delete();
            q1.delete();
        end else begin
            checks++;
            if (m_axis_rq_tvalid !== exp_ov) begin
                failures++;
                $display("FAIL m_tvalid: got %b expected %b", m_axis_rq_tvalid, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (m_axis_rq_tdata !== exp_out.d || m_axis_rq_tkeep !== exp_out.k ||
                    m_axis_rq_tlast !== exp_out.l || m_axis_rq_tuser !== exp_out.u) begin
                    failures++;
                    $display("FAIL m_beat: got d=%h l=%b k=%h expected d=%h l=%b k=%h",
                             m_axis_rq_tdata, m_axis_rq_tlast, m_axis_rq_tkeep, exp_out.d, exp_out.l, exp_out.k);
                end
            end
            checks++;
            if (pkt_cnt0 !== 16'(cnt[0]) || pkt_cnt1 !== 16'(cnt[1])) begin
                failures++;
                $display("FAIL pkt_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1, 16'(cnt[0]), 16'(cnt[1]));
            end
            if (log_en && m_axis_rq_tvalid === 1'b1 && m_axis_rq_tready) begin
                ob.d = m_axis_rq_tdata; ob.k = m_axis_rq_tkeep; ob.l = m_axis_rq_tlast; ob.u = m_axis_rq_tuser;
                out_log.push_back(ob);
            end

            can_load = !exp_ov || m_axis_rq_tready;
            if (owner >= 0)                                w = owner;
            else if (s0_axis_rq_tvalid && s1_axis_rq_tvalid) w = (last_w == 1) ? 0 : 1;
            else if (s0_axis_rq_tvalid)                    w = 0;
            else if (s1_axis_rq_tvalid)                    w = 1;
            else                                           w = -1;
            exp_r0 = (w == 0) && can_load;
            exp_r1 = (w == 1) && can_load;
            acc    = ((w == 0 && s0_axis_rq_tvalid) || (w == 1 && s1_axis_rq_tvalid)) && can_load;
            if (owner == 0)      exp_g = 2'b01;
            else if (owner == 1) exp_g = 2'b10;
            else if (acc)        exp_g = (w == 0) ? 2'b01 : 2'b10;
            else                 exp_g = 2'b00;

            checks++;
            if (s0_axis_rq_tready !== exp_r0 || s1_axis_rq_tready !== exp_r1) begin
                failures++;
                $display("FAIL tready: got s0=%b s1=%b expected s0=%b s1=%b",
                         s0_axis_rq_tready, s1_axis_rq_tready, exp_r0, exp_r1);
            end
            checks++;
            if (grant !== exp_g) begin
                failures++;
                $display("FAIL grant: got %b expected %b", grant, exp_g);
            end

            eb = exp_out;
            if (acc) begin
                b  = (w == 0) ? q0.pop_front() : q1.pop_front();
                eb = b;
                if (!in_pkt[w] && cfg_t1_to_t0[w]) eb.d[75] = 1'b0;
                in_pkt[w] = !b.l;
                if (owner < 0) last_w = w;
                owner = b.l ? -1 : w;
                if (b.l) cnt[w]++;
            end
            if (can_load) begin
                exp_ov = acc;
                if (acc) exp_out = eb;
            end
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic drain(int budget, string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_ov) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || exp_ov) begin
            failures++;
            $display("FAIL %s_drain: %0d input beats pending after %0d cycles, expected 0", name, q0.size() + q1.size(), budget);
        end
    endtask

    task automatic reset_dut();
        user_reset = 1'b1;
        cycle();
        cycle();
        user_reset = 1'b0;
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if (m_axis_rq_tvalid !== 1'b0 || grant !== 2'b00 || pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got tvalid=%b grant=%b cnt=%0d/%0d expected 0 00 0/0",
                     m_axis_rq_tvalid, grant, pkt_cnt0, pkt_cnt1);
        end
        checks++;
        if (m_axis_rq_tdata !== '0 || m_axis_rq_tkeep !== '0 || m_axis_rq_tlast !== 1'b0 || m_axis_rq_tuser !== '0) begin
            failures++;
            $display("FAIL reset_data: got nonzero m_axis payload (last=%b keep=%h), expected all zero",
                     m_axis_rq_tlast, m_axis_rq_tkeep);
        end
        user_reset = 1'b0;
    endtask

    task automatic test_t1_conversion();
        tb_beat_t     src[$];
        logic [W-1:0] exp_d;
        out_log.delete();
        cfg_t1_to_t0 = 2'b01;
        push_pkt(0, 1, 3, 1'b1, 1'b1);
        src = q0;
        cycle();
        checks++;
        if (m_axis_rq_tvalid !== 1'b1 || m_axis_rq_tdata[23:0] !== src[0].d[23:0]) begin
            failures++;
            $display("FAIL t1_latency: got tvalid=%b tag=%h expected 1 %h", m_axis_rq_tvalid, m_axis_rq_tdata[23:0], src[0].d[23:0]);
        end
        drain(20, "t1");
        checks++;
        if (out_log.size() != 3) begin
            failures++;
            $display("FAIL t1_count: got %0d beats expected 3", out_log.size());
        end else begin
            exp_d     = src[0].d;
            exp_d[75] = 1'b0;
            checks++;
            if (out_log[0].d !== exp_d || out_log[0].u !== src[0].u) begin
                failures++;
                $display("FAIL t1_first_beat: got bit75=%b expected 0 with other bits unchanged", out_log[0].d[75]);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (out_log[i].d !== src[i].d || out_log[i].k !== src[i].k ||
                    out_log[i].l !== src[i].l || out_log[i].u !== src[i].u) begin
                    failures++;
                    $display("FAIL t1_beat%0d: got bit75=%b tag=%h expected unmodified bit75=%b tag=%h",
                             i, out_log[i].d[75], out_log[i].d[23:0], src[i].d[75], src[i].d[23:0]);
                end
            end
        end
        checks++;
        if (pkt_cnt0 !== 16'd1) begin
            failures++;
            $display("FAIL t1_pkt_cnt0: got %0d expected 1", pkt_cnt0);
        end
    endtask

    task automatic test_alternation();
        logic [23:0] exp_tag;
        reset_dut();
        out_log.delete();
        cfg_t1_to_t0 = 2'b00;
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, p, 2, 1'b0, 1'b0);
            push_pkt(1, p, 2, 1'b0, 1'b0);
        end
        drain(100, "alternation");
        checks++;
        if (out_log.size() != 16) begin
            failures++;
            $display("FAIL alt_count: got %0d beats expected 16", out_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_tag = {8'(i % 2), 8'(i / 4), 8'((i / 2) % 2)};
                checks++;
                if (out_log[i].d[23:0] !== exp_tag) begin
                    failures++;
                    $display("FAIL alt_order[%0d]: got tag=%h expected %h", i, out_log[i].d[23:0], exp_tag);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] snap;
        out_log.delete();
        m_axis_rq_tready = 1'b1;
        push_pkt(0, 5, 5, 1'b0, 1'b0);
        push_pkt(1, 5, 1, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        m_axis_rq_tready = 1'b0;
        snap = m_axis_rq_tdata;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (m_axis_rq_tvalid !== 1'b1 || m_axis_rq_tdata !== snap ||
                s0_axis_rq_tready !== 1'b0 || s1_axis_rq_tready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got tvalid=%b tag=%h rdy=%b%b expected 1 %h 00",
                         i, m_axis_rq_tvalid, m_axis_rq_tdata[23:0], s0_axis_rq_tready, s1_axis_rq_tready, snap[23:0]);
            end
        end
        m_axis_rq_tready = 1'b1;
        drain(40, "stall");
        checks++;
        if (out_log.size() != 6) begin
            failures++;
            $display("FAIL stall_count: got %0d beats expected 6", out_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_log[i].d[23:0] !== {8'(i), 8'd5, 8'd0}) begin
                    failures++;
                    $display("FAIL stall_seq[%0d]: got tag=%h expected %h", i, out_log[i].d[23:0], {8'(i), 8'd5, 8'd0});
                end
            end
        end
    endtask

    task automatic test_cfg_passthrough();
        tb_beat_t src[$];
        out_log.delete();
        cfg_t1_to_t0 = 2'b00;
        push_pkt(1, 7, 3, 1'b1, 1'b1);
        src = q1;
        cycle();
        cfg_t1_to_t0 = 2'b11;
        drain(20, "cfg_keep");
        checks++;
        if (out_log.size() != 3) begin
            failures++;
            $display("FAIL cfg_keep_count: got %0d beats expected 3", out_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_log[i].d !== src[i].d) begin
                    failures++;
                    $display("FAIL cfg_keep[%0d]: got bit75=%b expected %b", i, out_log[i].d[75], src[i].d[75]);
                end
            end
        end
        out_log.delete();
        cfg_t1_to_t0 = 2'b10;
        push_pkt(1, 8, 3, 1'b1, 1'b1);
        cycle();
        cfg_t1_to_t0 = 2'b00;
        drain(20, "cfg_clear");
        checks++;
        if (out_log.size() != 3) begin
            failures++;
            $display("FAIL cfg_clear_count: got %0d beats expected 3", out_log.size());
        end else begin
            checks++;
            if (out_log[0].d[75] !== 1'b0 || out_log[1].d[75] !== 1'b1 || out_log[2].d[75] !== 1'b1) begin
                failures++;
                $display("FAIL cfg_clear: got bit75=%b%b%b expected 011",
                         out_log[0].d[75], out_log[1].d[75], out_log[2].d[75]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        cfg_t1_to_t0 = 2'b00;
        push_pkt(0, 9, 1, 1'b0, 1'b0);
        drain(20, "pre_reset");
        push_pkt(0, 10, 4, 1'b0, 1'b0);
        cycle();
        cycle();
        user_reset = 1'b1;
        cycle();
        checks++;
        if (m_axis_rq_tvalid !== 1'b0 || grant !== 2'b00 || pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
            failures++;
            $display("FAIL mid_reset: got tvalid=%b grant=%b cnt=%0d/%0d expected 0 00 0/0",
                     m_axis_rq_tvalid, grant, pkt_cnt0, pkt_cnt1);
        end
        user_reset = 1'b0;
        out_log.delete();
        push_pkt(0, 11, 1, 1'b0, 1'b0);
        push_pkt(1, 11, 1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (m_axis_rq_tvalid !== 1'b1 || m_axis_rq_tdata[7:0] !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_tie: got tvalid=%b src=%0d expected 1 0", m_axis_rq_tvalid, m_axis_rq_tdata[7:0]);
        end
        drain(20, "post_reset");
    endtask

    task automatic test_random();
        reset_dut();
        gap_pct  = 30;
        rand_rdy = 1'b1;
        for (int p = 0; p < 25; p++) begin
            push_pkt(0, p, 1 + $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)));
            push_pkt(1, p, 1 + $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        for (int i = 0; i < 600; i++) begin
            cfg_t1_to_t0 = 2'($urandom);
            cycle();
        end
        rand_rdy         = 1'b0;
        gap_pct          = 0;
        m_axis_rq_tready = 1'b1;
        drain(400, "random");
    endtask

    task automatic test_counter_wrap();
        int pushed = 0;
        int n      = 0;
        reset_dut();
        log_en       = 1'b0;
        cfg_t1_to_t0 = 2'b00;
        while (cnt[1] < 65537 && n < 70000) begin
            if (q1.size() == 0 && pushed < 65537) begin
                push_pkt(1, pushed, 1, 1'b0, 1'b0);
                pushed++;
            end
            cycle();
            n++;
        end
        checks++;
        if (pkt_cnt1 !== 16'd1) begin
            failures++;
            $display("FAIL cnt_wrap: got pkt_cnt1=%0d after %0d packets expected 1", pkt_cnt1, cnt[1]);
        end
        drain(10, "wrap");
        log_en = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_t1_conversion();
        test_alternation();
        test_stall();
        test_cfg_passthrough();
        test_reset_mid_packet();
        test_random();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
